// File: rtl/noc_arb_pkg.sv
// Shared definitions for the mesh-router switch allocators.
package noc_arb_pkg;

   localparam int N_PORTS_DEFAULT = 5;

   // Router port numbering
   localparam int P_LOCAL = 0;
   localparam int P_N     = 1;
   localparam int P_E     = 2;
   localparam int P_S     = 3;
   localparam int P_W     = 4;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_switch_arbiter_if.sv
// Request/grant bundle between input-port request logic and one output allocator.
interface rr_switch_arbiter_if
   import noc_arb_pkg::*;
#(
   parameter int N_PORTS = N_PORTS_DEFAULT,
   parameter int IDX_W   = $clog2(N_PORTS)
);
   logic [N_PORTS-1:0] req;
   logic [N_PORTS-1:0] req_tail;
   logic               out_ready;
   logic [N_PORTS-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               busy;
   logic               xfer;

   // Requester / downstream side
   modport master (
      output req, req_tail, out_ready,
      input  grant, grant_idx, busy, xfer
   );

   // Allocator side
   modport slave (
      input  req, req_tail, out_ready,
      output grant, grant_idx, busy, xfer
   );
endinterface

// File: rtl/rr_switch_arbiter_pick.sv
// Combinational masked priority encoder. The request vector is duplicated;
// the low copy is masked by a thermometer starting at rr_ptr, so the lowest
// set bit of the doubled vector is the first requester at or after rr_ptr,
// falling back to the unmasked copy when nothing at/after rr_ptr requests.
// With RR_MODE=0 the mask is empty and the result is plain lowest-index-wins.
module rr_priority_pick
   import noc_arb_pkg::*;
#(
   parameter int N_PORTS = N_PORTS_DEFAULT,
   parameter int RR_MODE = 1
) (
   input  logic [N_PORTS-1:0]         req,
   input  logic [$clog2(N_PORTS)-1:0] rr_ptr,
   output logic [N_PORTS-1:0]         winner,
   output logic [$clog2(N_PORTS)-1:0] idx
);
   localparam int IDX_W = $clog2(N_PORTS);
   localparam int DBL_W = 2 * N_PORTS;
   localparam int POS_W = $clog2(DBL_W);

   logic [N_PORTS-1:0] therm_mask;
   logic [DBL_W-1:0]   dbl_req;
   logic [POS_W-1:0]   pos;

   generate
      for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_mask
         assign therm_mask[gi] = (RR_MODE != 0) && (IDX_W'(gi) >= rr_ptr);
      end
   endgenerate

   assign dbl_req = {req, req & therm_mask};

   // Lowest set bit of the doubled vector (later iterations override earlier)
   always_comb begin
      pos = '0;
      for (int i = DBL_W - 1; i >= 0; i--) begin
         if (dbl_req[i]) begin
            pos = POS_W'(i);
         end
      end
   end

   // Fold the doubled position back into a port index
   always_comb begin
      if (pos >= POS_W'(N_PORTS)) begin
         idx = IDX_W'(pos - POS_W'(N_PORTS));
      end else begin
         idx = IDX_W'(pos);
      end
   end

   generate
      for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_onehot
         assign winner[gi] = (|req) && (idx == IDX_W'(gi));
      end
   endgenerate
endmodule

// File: rtl/rr_switch_arbiter.sv
// Per-output-port wormhole switch allocator: arbitrates in IDLE, then holds
// the grant until the granted packet's tail flit is transferred.
module rr_switch_arbiter
   import noc_arb_pkg::*;
#(
   parameter int N_PORTS = N_PORTS_DEFAULT,
   parameter int RR_MODE = 1
) (
   input  logic                clk,
   input  logic                rst,
   rr_switch_arbiter_if.slave  arb
);
   localparam int IDX_W = $clog2(N_PORTS);

   arb_state_t         state_reg, state_next;
   logic [N_PORTS-1:0] grant_reg, grant_next;
   logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
   logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;

   logic [N_PORTS-1:0] pick_winner;
   logic [IDX_W-1:0]   pick_idx;
   logic               busy_w;
   logic               xfer_w;
   logic               release_w;

   rr_priority_pick #(
      .N_PORTS (N_PORTS),
      .RR_MODE (RR_MODE)
   ) u_pick (
      .req    (arb.req),
      .rr_ptr (rr_ptr_reg),
      .winner (pick_winner),
      .idx    (pick_idx)
   );

   // State, grant and round-robin pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ARB_IDLE;
         grant_reg     <= '0;
         grant_idx_reg <= '0;
         rr_ptr_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         grant_reg     <= grant_next;
         grant_idx_reg <= grant_idx_next;
         rr_ptr_reg    <= rr_ptr_next;
      end
   end

   // Next state: lock on any request, release on the granted tail transfer
   always_comb begin
      state_next     = state_reg;
      grant_next     = grant_reg;
      grant_idx_next = grant_idx_reg;
      rr_ptr_next    = rr_ptr_reg;
      case (state_reg)
         ARB_IDLE: begin
            if (|arb.req) begin
               state_next     = ARB_LOCKED;
               grant_next     = pick_winner;
               grant_idx_next = pick_idx;
            end
         end
         ARB_LOCKED: begin
            if (release_w) begin
               state_next     = ARB_IDLE;
               grant_next     = '0;
               grant_idx_next = '0;
               if (grant_idx_reg == IDX_W'(N_PORTS - 1)) begin
                  rr_ptr_next = '0;
               end else begin
                  rr_ptr_next = grant_idx_reg + IDX_W'(1);
               end
            end
         end
         default: begin
            state_next     = ARB_IDLE;
            grant_next     = '0;
            grant_idx_next = '0;
         end
      endcase
   end

   // Outputs: transfer strobe only for the locked port while downstream is ready
   always_comb begin
      busy_w        = (state_reg == ARB_LOCKED);
      xfer_w        = busy_w & arb.out_ready & arb.req[grant_idx_reg];
      release_w     = xfer_w & arb.req_tail[grant_idx_reg];
      arb.busy      = busy_w;
      arb.xfer      = xfer_w;
      arb.grant     = grant_reg;
      arb.grant_idx = grant_idx_reg;
   end
endmodule

// File: tb/tb_rr_switch_arbiter.sv
// Directed bench: one round-robin and one fixed-priority allocator share stimulus.
module tb_rr_switch_arbiter;
   import noc_arb_pkg::*;

   localparam int N = 5;

   logic clk;
   logic rst;
   logic [N-1:0] req_v;
   logic [N-1:0] tail_v;
   logic         ready_v;

   int tests_run;
   int tests_failed;

   rr_switch_arbiter_if #(.N_PORTS(N)) if_rr ();
   rr_switch_arbiter_if #(.N_PORTS(N)) if_fp ();

   assign if_rr.req       = req_v;
   assign if_rr.req_tail  = tail_v;
   assign if_rr.out_ready = ready_v;
   assign if_fp.req       = req_v;
   assign if_fp.req_tail  = tail_v;
   assign if_fp.out_ready = ready_v;

   rr_switch_arbiter #(.N_PORTS(N), .RR_MODE(1)) u_rr (
      .clk (clk),
      .rst (rst),
      .arb (if_rr.slave)
   );

   rr_switch_arbiter #(.N_PORTS(N), .RR_MODE(0)) u_fp (
      .clk (clk),
      .rst (rst),
      .arb (if_fp.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      req_v   = '0;
      tail_v  = '0;
      ready_v = 1'b1;
      rst     = 1'b1;
      step();
      rst     = 1'b0;
   endtask

   task automatic test_reset;
      req_v   = '0;
      tail_v  = '0;
      ready_v = 1'b1;
      rst     = 1'b1;
      #1;
      tests_run++;
      if (if_rr.grant !== 5'b00000 || if_rr.busy !== 1'b0 || if_rr.grant_idx !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_assert grant=%b busy=%b idx=%0d, want 00000/0/0",
                  if_rr.grant, if_rr.busy, if_rr.grant_idx);
      end
      step();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         tests_run++;
         if (if_rr.grant !== 5'b00000 || if_rr.busy !== 1'b0 ||
             if_rr.grant_idx !== 3'd0 || if_rr.xfer !== 1'b0 ||
             if_fp.grant !== 5'b00000 || if_fp.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_noreq cyc=%0d rr grant=%b busy=%b idx=%0d xfer=%b fp grant=%b busy=%b, want all zero",
                     c, if_rr.grant, if_rr.busy, if_rr.grant_idx, if_rr.xfer, if_fp.grant, if_fp.busy);
         end
      end
      $display("[TB] reset/idle: 10 cycles with no request");
   endtask

   task automatic test_round_robin;
      logic [N-1:0] exp_g [4];
      logic [2:0]   exp_i [4];
      exp_g = '{5'b00010, 5'b00100, 5'b10000, 5'b00010};
      exp_i = '{3'd1, 3'd2, 3'd4, 3'd1};
      do_reset();
      req_v  = 5'b10110;
      tail_v = 5'b11111;
      for (int k = 0; k < 4; k++) begin
         step();
         tests_run++;
         if (if_rr.grant !== exp_g[k] || if_rr.grant_idx !== exp_i[k] ||
             if_rr.busy !== 1'b1 || if_rr.xfer !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_grant pkt=%0d grant=%b idx=%0d busy=%b xfer=%b, want %b/%0d/1/1",
                     k, if_rr.grant, if_rr.grant_idx, if_rr.busy, if_rr.xfer, exp_g[k], exp_i[k]);
         end
         $display("[TB] rr packet %0d granted %b", k, if_rr.grant);
         step();
         tests_run++;
         if (if_rr.grant !== 5'b00000 || if_rr.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_bubble pkt=%0d grant=%b busy=%b, want 00000/0",
                     k, if_rr.grant, if_rr.busy);
         end
      end
   endtask

   task automatic test_fixed_priority;
      do_reset();
      req_v  = 5'b10110;
      tail_v = 5'b11111;
      for (int k = 0; k < 4; k++) begin
         step();
         tests_run++;
         if (if_fp.grant !== 5'b00010 || if_fp.grant_idx !== 3'd1 || if_fp.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL fp_grant pkt=%0d grant=%b idx=%0d busy=%b, want 00010/1/1",
                     k, if_fp.grant, if_fp.grant_idx, if_fp.busy);
         end
         $display("[TB] fp packet %0d granted %b", k, if_fp.grant);
         step();
         tests_run++;
         if (if_fp.grant !== 5'b00000 || if_fp.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL fp_bubble pkt=%0d grant=%b busy=%b, want 00000/0",
                     k, if_fp.grant, if_fp.busy);
         end
      end
   endtask

   task automatic test_wormhole;
      do_reset();
      req_v  = 5'b00100;
      tail_v = 5'b00000;
      step();
      // flit 1 transfers this cycle
      tests_run++;
      if (if_rr.grant !== 5'b00100 || if_rr.grant_idx !== 3'(P_E) || if_rr.xfer !== 1'b1) begin
         tests_failed++;
         $display("FAIL wh_lock grant=%b idx=%0d xfer=%b, want 00100/2/1",
                  if_rr.grant, if_rr.grant_idx, if_rr.xfer);
      end
      step();
      // downstream stall for two cycles, competing request on port 0
      ready_v = 1'b0;
      req_v   = 5'b00101;
      #1;
      tests_run++;
      if (if_rr.xfer !== 1'b0) begin
         tests_failed++;
         $display("FAIL wh_stall_xfer xfer=%b, want 0", if_rr.xfer);
      end
      step();
      step();
      tests_run++;
      if (if_rr.grant !== 5'b00100 || if_rr.busy !== 1'b1 || if_rr.xfer !== 1'b0) begin
         tests_failed++;
         $display("FAIL wh_stall_hold grant=%b busy=%b xfer=%b, want 00100/1/0",
                  if_rr.grant, if_rr.busy, if_rr.xfer);
      end
      // flit 2
      ready_v = 1'b1;
      #1;
      tests_run++;
      if (if_rr.xfer !== 1'b1) begin
         tests_failed++;
         $display("FAIL wh_resume xfer=%b, want 1", if_rr.xfer);
      end
      step();
      // granted input runs dry without a tail
      req_v = 5'b00001;
      #1;
      tests_run++;
      if (if_rr.xfer !== 1'b0) begin
         tests_failed++;
         $display("FAIL wh_dry_xfer xfer=%b, want 0", if_rr.xfer);
      end
      step();
      tests_run++;
      if (if_rr.grant !== 5'b00100) begin
         tests_failed++;
         $display("FAIL wh_dry_hold grant=%b, want 00100", if_rr.grant);
      end
      // flit 3
      req_v = 5'b00101;
      step();
      // flit 4 is the tail; a tail on port 0 must be ignored
      tail_v = 5'b00101;
      #1;
      tests_run++;
      if (if_rr.xfer !== 1'b1 || if_rr.grant !== 5'b00100) begin
         tests_failed++;
         $display("FAIL wh_tail_xfer xfer=%b grant=%b, want 1/00100", if_rr.xfer, if_rr.grant);
      end
      step();
      tests_run++;
      if (if_rr.grant !== 5'b00000 || if_rr.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL wh_release grant=%b busy=%b, want 00000/0", if_rr.grant, if_rr.busy);
      end
      tail_v = 5'b00000;
      step();
      tests_run++;
      if (if_rr.grant !== 5'b00001 || if_rr.grant_idx !== 3'(P_LOCAL)) begin
         tests_failed++;
         $display("FAIL wh_next grant=%b idx=%0d, want 00001/0", if_rr.grant, if_rr.grant_idx);
      end
      $display("[TB] wormhole packet on port 2 released, port 0 granted %b", if_rr.grant);
   endtask

   task automatic test_wrap;
      do_reset();
      req_v  = 5'b01000;
      tail_v = 5'b11111;
      step();
      tests_run++;
      if (if_rr.grant !== 5'b01000) begin
         tests_failed++;
         $display("FAIL wrap_setup grant=%b, want 01000", if_rr.grant);
      end
      step();
      // pointer now 4
      req_v = 5'b10001;
      step();
      tests_run++;
      if (if_rr.grant !== 5'b10000 || if_rr.grant_idx !== 3'(P_W)) begin
         tests_failed++;
         $display("FAIL wrap_port4 grant=%b idx=%0d, want 10000/4", if_rr.grant, if_rr.grant_idx);
      end
      step();
      tests_run++;
      if (if_rr.grant !== 5'b00000 || if_rr.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL wrap_release grant=%b busy=%b, want 00000/0", if_rr.grant, if_rr.busy);
      end
      step();
      tests_run++;
      if (if_rr.grant !== 5'b00001 || if_rr.grant_idx !== 3'd0) begin
         tests_failed++;
         $display("FAIL wrap_port0 grant=%b idx=%0d, want 00001/0", if_rr.grant, if_rr.grant_idx);
      end
      $display("[TB] wrap: port 4 then port 0 granted");
   endtask

   task automatic test_async_reset;
      do_reset();
      req_v  = 5'b00100;
      tail_v = 5'b00100;
      step();
      step();
      // pointer now 3; port 3 beats port 1
      req_v  = 5'b01010;
      tail_v = 5'b00000;
      step();
      tests_run++;
      if (if_rr.grant !== 5'b01000) begin
         tests_failed++;
         $display("FAIL ar_setup grant=%b, want 01000", if_rr.grant);
      end
      step();
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if (if_rr.grant !== 5'b00000 || if_rr.busy !== 1'b0 || if_rr.grant_idx !== 3'd0) begin
         tests_failed++;
         $display("FAIL ar_immediate grant=%b busy=%b idx=%0d, want 00000/0/0",
                  if_rr.grant, if_rr.busy, if_rr.grant_idx);
      end
      #1;
      rst = 1'b0;
      step();
      tests_run++;
      if (if_rr.grant !== 5'b00010 || if_rr.grant_idx !== 3'd1) begin
         tests_failed++;
         $display("FAIL ar_restart grant=%b idx=%0d, want 00010/1", if_rr.grant, if_rr.grant_idx);
      end
      $display("[TB] async reset mid-packet, restart granted %b", if_rr.grant);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      req_v        = '0;
      tail_v       = '0;
      ready_v      = 1'b0;
      test_reset();
      test_round_robin();
      test_fixed_priority();
      test_wormhole();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
